// File: rtl/pc_sequencer.sv
// pc_sequencer: word-addressed program counter and next-PC selection for the MIPS fetch stage.
// Build option DELAY_SLOT_EN: branch-delay-slot semantics, flush held low.
module pc_sequencer #(
  parameter int unsigned PC_W     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic [15:0]     br_imm,
  input  logic            j_valid,
  input  logic [25:0]     j_index,
  input  logic [PC_W-1:0] j_pc,
  input  logic            jr_valid,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            redirect_pending
);

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned JHI_W  = PC_W - JIDX_W;

`ifdef DELAY_SLOT_EN
  localparam logic FLUSH_EN = 1'b0;
`else
  localparam logic FLUSH_EN = 1'b1;
`endif

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pend_target_q;
  logic [PC_W-1:0] pend_target_d;
  logic [PC_W-1:0] pc_d;
  logic            fetch_valid_d;
  logic            flush_d;
  logic            redirect_pending_d;

  logic [PC_W-1:0]  seq_pc;
  logic [PC_W-1:0]  br_target;
  logic [JHI_W-1:0] j_hi;
  logic             redir_req;
  logic [PC_W-1:0]  redir_target;

  // Candidate targets; all arithmetic wraps modulo 2^PC_W.
  assign seq_pc    = pc + PC_W'(1);
  assign br_target = br_pc + {{(PC_W-IMM_W){br_imm[IMM_W-1]}}, br_imm} + PC_W'(1);
  assign j_hi      = JHI_W'((j_pc + PC_W'(1)) >> JIDX_W);

  // Fixed-priority redirect select: jr > j > taken branch > sequential.
  always_comb begin
    redir_req    = 1'b1;
    redir_target = jr_target;
    if (jr_valid) begin
      redir_target = jr_target;
    end else if (j_valid) begin
      redir_target = {j_hi, j_index};
    end else if (br_valid && br_taken) begin
      redir_target = br_target;
    end else begin
      redir_req    = 1'b0;
      redir_target = seq_pc;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= BOOT;
      pc               <= RESET_PC[PC_W-1:0];
      pend_target_q    <= '0;
      fetch_valid      <= 1'b0;
      flush            <= 1'b0;
      redirect_pending <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc               <= pc_d;
      pend_target_q    <= pend_target_d;
      fetch_valid      <= fetch_valid_d;
      flush            <= flush_d;
      redirect_pending <= redirect_pending_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (stall && redir_req) state_d = PEND;
      PEND:    if (!stall) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Output and datapath next values; redirects arriving in PEND are dropped.
  always_comb begin
    pc_d          = pc;
    pend_target_d = pend_target_q;
    flush_d       = 1'b0;
    case (state_q)
      RUN: begin
        if (!stall) begin
          pc_d    = redir_target;
          flush_d = FLUSH_EN & redir_req;
        end else if (redir_req) begin
          pend_target_d = redir_target;
        end
      end
      PEND: begin
        if (!stall) begin
          pc_d          = pend_target_q;
          pend_target_d = '0;
          flush_d       = FLUSH_EN;
        end
      end
      default: ;
    endcase
    fetch_valid_d      = (state_d != BOOT);
    redirect_pending_d = (state_d == PEND);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle expectations queued with stimulus, popped after each edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_imm;
  logic        j_valid;
  logic [25:0] j_index;
  logic [31:0] j_pc;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        redirect_pending;

`ifdef DELAY_SLOT_EN
  localparam logic FL = 1'b0;
`else
  localparam logic FL = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  logic [34:0] sb[$];

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_taken         (br_taken),
    .br_pc            (br_pc),
    .br_imm           (br_imm),
    .j_valid          (j_valid),
    .j_index          (j_index),
    .j_pc             (j_pc),
    .jr_valid         (jr_valid),
    .jr_target        (jr_target),
    .pc               (pc),
    .fetch_valid      (fetch_valid),
    .flush            (flush),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input logic rst, input logic stl);
    reset     = rst;
    stall     = stl;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    br_pc     = 32'h0;
    br_imm    = 16'h0;
    j_valid   = 1'b0;
    j_index   = 26'h0;
    j_pc      = 32'h0;
    jr_valid  = 1'b0;
    jr_target = 32'h0;
  endtask

  task automatic push_exp(input logic [31:0] p, input logic fv, input logic fl, input logic rp);
    sb.push_back({p, fv, fl, rp});
  endtask

  task automatic set_br(input logic [31:0] bpc, input logic [15:0] imm);
    br_valid = 1'b1;
    br_taken = 1'b1;
    br_pc    = bpc;
    br_imm   = imm;
  endtask

  task automatic test_reset();
    logic [34:0] e, got;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 1: begin idle(1'b1, 1'b0); push_exp(32'h0, 1'b0, 1'b0, 1'b0); end
        2: begin
          idle(1'b0, 1'b0);
          jr_valid = 1'b1; jr_target = 32'h55;   // ignored while leaving BOOT
          push_exp(32'h0, 1'b1, 1'b0, 1'b0);
        end
        default: begin idle(1'b0, 1'b0); push_exp(32'(i - 2), 1'b1, 1'b0, 1'b0); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, fetch_valid, flush, redirect_pending}; total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset[%0d]: got pc=%h fv=%b fl=%b rp=%b want pc=%h fv=%b fl=%b rp=%b",
                 i, got[34:3], got[2], got[1], got[0], e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_branch();
    logic [34:0] e, got;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1'b0);
      case (i)
        0: begin set_br(32'h10, 16'h0005); push_exp(32'h16, 1'b1, FL, 1'b0); end
        1: push_exp(32'h17, 1'b1, 1'b0, 1'b0);
        2: begin set_br(32'h10, 16'hFFFC); push_exp(32'h0D, 1'b1, FL, 1'b0); end
        3: begin set_br(32'h50, 16'h0007); br_taken = 1'b0; push_exp(32'h0E, 1'b1, 1'b0, 1'b0); end
        default: push_exp(32'h0F, 1'b1, 1'b0, 1'b0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, fetch_valid, flush, redirect_pending}; total++;
      if (got !== e) begin
        bad++;
        $display("FAIL branch[%0d]: got pc=%h fv=%b fl=%b rp=%b want pc=%h fv=%b fl=%b rp=%b",
                 i, got[34:3], got[2], got[1], got[0], e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_priority();
    logic [34:0] e, got;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1'b0);
      case (i)
        0: begin
          jr_valid = 1'b1; jr_target = 32'h100;
          j_valid = 1'b1; j_pc = 32'h0BFF_FFFF; j_index = 26'h0ABCDE;
          set_br(32'h10, 16'h0005);
          push_exp(32'h100, 1'b1, FL, 1'b0);
        end
        1: begin
          j_valid = 1'b1; j_pc = 32'h0BFF_FFFF; j_index = 26'h0ABCDE;
          set_br(32'h10, 16'h0005);
          push_exp(32'h0C0A_BCDE, 1'b1, FL, 1'b0);
        end
        2: begin set_br(32'h20, 16'h0002); push_exp(32'h23, 1'b1, FL, 1'b0); end
        default: push_exp(32'h24, 1'b1, 1'b0, 1'b0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, fetch_valid, flush, redirect_pending}; total++;
      if (got !== e) begin
        bad++;
        $display("FAIL priority[%0d]: got pc=%h fv=%b fl=%b rp=%b want pc=%h fv=%b fl=%b rp=%b",
                 i, got[34:3], got[2], got[1], got[0], e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [34:0] e, got;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin idle(1'b0, 1'b1); push_exp(32'h24, 1'b1, 1'b0, 1'b0); end
        1: begin idle(1'b0, 1'b1); set_br(32'h3F, 16'h0000); push_exp(32'h24, 1'b1, 1'b0, 1'b1); end
        2: begin idle(1'b0, 1'b1); jr_valid = 1'b1; jr_target = 32'h999; push_exp(32'h24, 1'b1, 1'b0, 1'b1); end
        3: begin idle(1'b0, 1'b1); push_exp(32'h24, 1'b1, 1'b0, 1'b1); end
        4: begin idle(1'b0, 1'b0); jr_valid = 1'b1; jr_target = 32'h999; push_exp(32'h40, 1'b1, FL, 1'b0); end
        default: begin idle(1'b0, 1'b0); push_exp(32'h41, 1'b1, 1'b0, 1'b0); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, fetch_valid, flush, redirect_pending}; total++;
      if (got !== e) begin
        bad++;
        $display("FAIL stall[%0d]: got pc=%h fv=%b fl=%b rp=%b want pc=%h fv=%b fl=%b rp=%b",
                 i, got[34:3], got[2], got[1], got[0], e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [34:0] e, got;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1'b0);
      case (i)
        0: begin jr_valid = 1'b1; jr_target = 32'hFFFF_FFFF; push_exp(32'hFFFF_FFFF, 1'b1, FL, 1'b0); end
        1: push_exp(32'h0, 1'b1, 1'b0, 1'b0);
        2: begin set_br(32'hFFFF_FFFE, 16'h0001); push_exp(32'h0, 1'b1, FL, 1'b0); end
        3: begin set_br(32'h5, 16'h8000); push_exp(32'hFFFF_8006, 1'b1, FL, 1'b0); end
        default: push_exp(32'hFFFF_8007, 1'b1, 1'b0, 1'b0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, fetch_valid, flush, redirect_pending}; total++;
      if (got !== e) begin
        bad++;
        $display("FAIL wrap[%0d]: got pc=%h fv=%b fl=%b rp=%b want pc=%h fv=%b fl=%b rp=%b",
                 i, got[34:3], got[2], got[1], got[0], e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_reset_pend();
    logic [34:0] e, got;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin idle(1'b0, 1'b1); jr_valid = 1'b1; jr_target = 32'h77; push_exp(32'hFFFF_8007, 1'b1, 1'b0, 1'b1); end
        1: begin idle(1'b1, 1'b1); jr_valid = 1'b1; jr_target = 32'h88; push_exp(32'h0, 1'b0, 1'b0, 1'b0); end
        2: begin idle(1'b0, 1'b1); push_exp(32'h0, 1'b1, 1'b0, 1'b0); end
        default: begin idle(1'b0, 1'b0); push_exp(32'(i - 2), 1'b1, 1'b0, 1'b0); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, fetch_valid, flush, redirect_pending}; total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_pend[%0d]: got pc=%h fv=%b fl=%b rp=%b want pc=%h fv=%b fl=%b rp=%b",
                 i, got[34:3], got[2], got[1], got[0], e[34:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    idle(1'b1, 1'b0);
    test_reset();
    test_branch();
    test_priority();
    test_stall();
    test_wrap();
    test_reset_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the word-addressed program counter and sequences next-PC selection for the MIPS core.
- Selects among sequential, taken-branch, jump and jump-register sources.
- Computes branch targets internally as pc + sext(imm16) + 1, the core's word-addressed convention.
- Sits between decode (redirect requests) and instruction memory (fetch address). Handles stalls, pending redirects and the wrong-path flush.

Parameters:
- RESET_PC, 32'h0000_0000, word address loaded on reset.
- PC_W, 32, PC width. Only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous reset, active-high
- stall  in  1  hold PC (fetch/decode hazard)
- br_valid  in  1  conditional branch resolved in decode this cycle
- br_taken  in  1  branch outcome; qualified by br_valid
- br_pc  in  32  word PC of the branch instruction
- br_imm  in  16  signed branch offset
- j_valid  in  1  J/JAL in decode
- j_index  in  26  jump target index
- j_pc  in  32  word PC of the jump instruction
- jr_valid  in  1  JR/JALR in decode
- jr_target  in  32  register target (word address)
- pc  out  32  current fetch address
- fetch_valid  out  1  pc is a live fetch this cycle
- flush  out  1  squash instruction fetched at the previous pc
- redirect_pending  out  1  redirect latched while stalled

Behaviour:
- Reset is synchronous: pc=RESET_PC, fetch_valid=0, flush=0, redirect_pending=0, pending target cleared, state=BOOT. Reset overrides every other input, including in mid-stall or mid-PEND; a latched redirect is discarded.
- States:
  - BOOT: one cycle with fetch_valid=0; pc holds RESET_PC. Next state is RUN unconditionally, ignoring stall and redirects.
  - RUN: fetch_valid=1.
    - stall=0: pc <= selected next PC.
    - stall=1: pc holds. Any redirect present is latched into the pending register (target + flag); go to PEND.
  - PEND: fetch_valid=1, redirect_pending=1, pc holds while stall=1.
    - New redirect inputs are ignored in PEND; upstream must not issue a second redirect before the first is applied.
    - First cycle with stall=0: pc <= pending target, pending cleared, flush pulse (see below), return to RUN.
- Next-PC priority, highest first:
  - jr_valid: jr_target.
  - j_valid: {j_pc_plus1[31:26], j_index}, where j_pc_plus1 = j_pc + 1.
  - br_valid & br_taken: br_pc + {{16{br_imm[15]}}, br_imm} + 1.
  - Otherwise: pc + 1.
- Simultaneous redirects are resolved by this priority; lower-priority requests are dropped silently.
- br_valid & !br_taken is treated as sequential.
- Arithmetic is modulo 2^32 with no overflow flag. 32'hFFFF_FFFF + 1 = 0; negative offsets wrap normally.
- flush is registered and asserts for exactly one cycle, in the cycle after pc is loaded with a redirect target. It is never asserted in BOOT or during reset.
- Latency: redirect presented at edge N (stall=0) → pc=target after edge N, flush=1 during cycle N+1.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Defined: MIPS branch-delay semantics. The instruction at redirect_source+1 executes, so flush is never asserted (tied 0). Pending redirects behave identically otherwise.
- Undefined: the flush behaviour described above.

Test Plan:
- Reset then run: reset for 2 cycles, release → BOOT cycle with fetch_valid=0, pc=0; then pc=0,1,2,3 on successive cycles with fetch_valid=1 and flush=0.
- Taken branch: br_pc=0x10, br_imm=16'h0005, taken → next pc=0x16, flush=1 for one cycle. br_imm=16'hFFFC from br_pc=0x10 → pc=0x0D.
- Priority: jr_valid (jr_target=0x100), j_valid and a taken branch all in the same cycle → pc=0x100. Same cycle without jr → jump target {j_pc+1[31:26], j_index}.
- Stall/pending: stall=1 plus a taken branch to 0x40 → pc holds, redirect_pending=1 for 3 stall cycles. stall drops → pc=0x40, flush=1, redirect_pending=0.
- Wrap and reset mid-PEND: pc=32'hFFFF_FFFF, no redirect → pc=0. Reset asserted while in PEND → pending cleared, pc=RESET_PC, BOOT re-entered.
- DELAY_SLOT_EN: rerun the taken-branch case → pc=0x16, flush stays 0 for all cycles.
